// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered 8N1 UART transmitter: FSM encoding
// and elaboration-time helpers for bit period and counter sizing.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Bit period in clocks, rounded to nearest.
  function automatic int calc_div(input int fck, input int baud);
    return (fck + baud / 2) / baud;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with show-ahead read and a registered occupancy count.
module uart_sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int C_FIFO_AW = 4
) (
  input  logic                 gclk,
  input  logic                 grst_n,
  input  logic                 push,
  input  logic [7:0]           din,
  input  logic                 pop,
  output logic [7:0]           dout,
  output logic [C_FIFO_AW:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 1 << C_FIFO_AW;
  localparam logic [C_FIFO_AW:0] FULL_CNT = {1'b1, {C_FIFO_AW{1'b0}}};

  logic [7:0]           mem [DEPTH];
  logic [C_FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic                 do_push, do_pop;

  // Flags come from the registered count, so a push while full is refused
  // even when a pop happens on the same edge.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge gclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a baud-timed shifter.
// Frames are back-to-back whenever the FIFO holds data at the end of a stop bit.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int C_FCK       = 48_000_000,
  parameter int C_BAUD_RATE = 19_200,
  parameter int C_FIFO_AW   = 4
) (
  input  logic       CK_i,
  input  tri1        XARST_i,
  input  logic [7:0] DAT_i,
  input  logic       WR_i,
  output logic       FULL_o,
  output logic       BUSY_o,
  output logic       OVF_o,
  output logic       TXD_o
);

  localparam int C_DIV = calc_div(C_FCK, C_BAUD_RATE);
  localparam int BW    = clog2(C_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(C_DIV - 1);

  if (C_DIV < 2) begin : g_div_chk
    $error("uart_tx_fifo: bit period C_DIV must be at least 2 clocks");
  end

  tx_state_e            state, state_nx;
  logic [BW-1:0]        baud_cnt, baud_nx;
  logic [2:0]           bit_cnt, bit_nx;
  logic [7:0]           shreg, sh_nx;
  logic                 txd_q, txd_nx;
  logic                 ovf_q;
  logic                 pop;
  logic                 baud_tick;
  logic [7:0]           fifo_dout;
  logic [C_FIFO_AW:0]   fifo_count;
  logic                 fifo_full, fifo_empty;

  uart_sync_fifo #(.C_FIFO_AW(C_FIFO_AW)) u_fifo (
    .gclk   (CK_i),
    .grst_n (XARST_i),
    .push   (WR_i),
    .din    (DAT_i),
    .pop    (pop),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign baud_tick = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt + 1'b1;
    bit_nx   = bit_cnt;
    sh_nx    = shreg;
    txd_nx   = txd_q;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_nx = '0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          sh_nx    = fifo_dout;
          txd_nx   = 1'b0;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          baud_nx  = '0;
          bit_nx   = '0;
          txd_nx   = shreg[0];
          sh_nx    = {1'b0, shreg[7:1]};
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          baud_nx = '0;
          if (bit_cnt == 3'd7) begin
            txd_nx   = 1'b1;
            state_nx = ST_STOP;
          end else begin
            bit_nx = bit_cnt + 1'b1;
            txd_nx = shreg[0];
            sh_nx  = {1'b0, shreg[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          baud_nx = '0;
          // Chain straight into the next start bit to keep frames contiguous.
          if (!fifo_empty) begin
            pop      = 1'b1;
            sh_nx    = fifo_dout;
            txd_nx   = 1'b0;
            state_nx = ST_START;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      txd_q    <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shreg    <= sh_nx;
      txd_q    <= txd_nx;
      ovf_q    <= ovf_q | (WR_i & fifo_full);
    end
  end

  assign FULL_o = fifo_full;
  assign BUSY_o = (state != ST_IDLE) || (fifo_count != '0);
  assign OVF_o  = ovf_q;
  assign TXD_o  = txd_q;

endmodule
